// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer.
//   tone_state_t : playback FSM states
//   VOL_W        : note volume width
//   note_t       : note record at the default widths
package tone_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} tone_state_t;

    localparam int unsigned VOL_W              = 3;
    localparam int unsigned PERIOD_W_DEFAULT   = 32;
    localparam int unsigned DUR_W_DEFAULT      = 16;
    localparam int unsigned TICK_DIV_DEFAULT   = 100000;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [PERIOD_W_DEFAULT-1:0] period;
        logic [DUR_W_DEFAULT-1:0]    dur;
        logic [VOL_W-1:0]            vol;
    } note_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO holding queued notes.
// Ports:
//   clock100 : clock
//   reset    : synchronous active-high reset
//   clear    : synchronous flush of all entries
//   push     : write wdata (ignored when full)
//   wdata    : entry to write
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry (valid when not empty)
//   full     : no free entries
//   empty    : no stored entries
//   count    : number of stored entries
module note_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock100,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wptr_q - rptr_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wptr_q == rptr_q);
    assign rdata   = mem[rptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock100) begin
        if (reset || clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock100) begin
        if (do_push && !reset && !clear) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Queued square-wave tone player. Notes {period, dur, vol} are accepted over a
// valid/ready handshake and played back-to-back on audPWM, separated by one
// LOAD cycle. Period is in clock cycles; period 0/1 is a rest.
// Optional feature macro: TONE_VOLUME_EN (3-bit PWM volume gating of the high
// phase; when undefined note_vol is ignored and not stored).
// Ports:
//   clock100    : 100 MHz clock
//   reset       : synchronous active-high reset
//   note_valid  : note offered
//   note_ready  : queue can accept (low while full or flushing)
//   note_period : tone period in clock cycles
//   note_dur    : duration in ticks of TICK_DIV cycles; 0 discards the note
//   note_vol    : volume 0..7
//   flush       : abort playing note and empty the queue
//   busy        : queue non-empty or a note in progress
//   audPWM      : audio waveform
//   audEn       : amplifier enable, high while a non-rest note plays
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned PERIOD_W   = 32,
    parameter int unsigned DUR_W      = 16,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clock100,
    input  logic                reset,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PERIOD_W-1:0] note_period,
    input  logic [DUR_W-1:0]    note_dur,
    input  logic [VOL_W-1:0]    note_vol,
    input  logic                flush,
    output logic                busy,
    output logic                audPWM,
    output logic                audEn
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef TONE_VOLUME_EN
    localparam int unsigned NOTE_W = PERIOD_W + DUR_W + VOL_W;
`else
    localparam int unsigned NOTE_W = PERIOD_W + DUR_W;
`endif

    tone_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] period_q;
    logic [DUR_W-1:0]    dur_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PRE_W-1:0]    pre_q;

    logic [NOTE_W-1:0]   fifo_wdata;
    logic [NOTE_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                pop;

    logic [PERIOD_W-1:0] head_period;
    logic [DUR_W-1:0]    head_dur;
    logic                tick;
    logic                last_cycle;
    logic                tone_on;
    logic                sq;

    assign note_ready = !fifo_full && !flush;
    assign push       = note_valid && note_ready;

`ifdef TONE_VOLUME_EN
    logic [VOL_W-1:0] head_vol;
    logic [VOL_W-1:0] vol_q;
    logic [2:0]       car_q;

    assign fifo_wdata = {note_period, note_dur, note_vol};
    assign head_vol   = fifo_rdata[VOL_W-1:0];
`else
    logic vol_unused;

    assign fifo_wdata = {note_period, note_dur};
    assign vol_unused = ^note_vol;
`endif

    assign head_period = fifo_rdata[NOTE_W-1 -: PERIOD_W];
    assign head_dur    = fifo_rdata[NOTE_W-PERIOD_W-1 -: DUR_W];

    note_fifo #(
        .WIDTH (NOTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock100 (clock100),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .wdata    (fifo_wdata),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign tick       = (pre_q == PRE_W'(TICK_DIV - 1));
    assign last_cycle = tick && (dur_q == DUR_W'(1));
    assign tone_on    = (state_q == PLAY) && (period_q >= PERIOD_W'(2));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                pop = 1'b1;
                // A zero-duration note is dropped; the next one (if any) loads at once.
                if (head_dur != '0)                  state_d = PLAY;
                else if (fifo_count > CNT_W'(1))     state_d = LOAD;
                else                                 state_d = IDLE;
            end
            PLAY: begin
                if (last_cycle) state_d = fifo_empty ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clock100) begin
        if (reset) begin
            state_q  <= IDLE;
            period_q <= '0;
            dur_q    <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                period_q <= head_period;
                dur_q    <= head_dur;
                cnt_q    <= '0;
                pre_q    <= '0;
            end else if (state_q == PLAY) begin
                pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                if (tick) dur_q <= dur_q - DUR_W'(1);
                if (tone_on) begin
                    cnt_q <= (cnt_q >= period_q - PERIOD_W'(1)) ? '0 : cnt_q + PERIOD_W'(1);
                end
            end
        end
    end

    // High for the first floor(period/2) cycles of each period.
    assign sq    = tone_on && (cnt_q < (period_q >> 1));
    assign audEn = tone_on;
    assign busy  = !fifo_empty || (state_q != IDLE);

`ifdef TONE_VOLUME_EN
    always_ff @(posedge clock100) begin
        if (reset) begin
            vol_q <= '0;
            car_q <= '0;
        end else begin
            car_q <= car_q + 3'd1;
            if (state_q == LOAD) vol_q <= head_vol;
        end
    end

    // Carrier gating gives duty (vol+1)/8 within the high phase.
    assign audPWM = sq && (car_q <= vol_q);
`else
    assign audPWM = sq;
`endif

endmodule
